// File: rtl/ledsd_scan_lbus_pkg.sv
// Shared types, field positions and local-bus match helpers for the scanned
// seven-segment display slave.
package ledsd_pkg;

  localparam int EN_BIT        = 0;
  localparam int HEX_BIT       = 1;
  localparam int HEX_DP_BIT    = 4;
  localparam int HEX_BLANK_BIT = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] wdata;
  } lb_slave_t;

  function automatic logic MatchWLB(input lb_slave_t xt, input logic [7:0] addr);
    return xt.wr && (xt.addr == addr);
  endfunction

  function automatic logic MatchRLB(input lb_slave_t xt, input logic [7:0] addr);
    return xt.rd && (xt.addr == addr);
  endfunction

endpackage

// File: rtl/ledsd_scan_lbus_if.sv
// Local-bus request/read-data bundle between a bus master and the
// scanned display slave.
interface ledsd_scan_lbus_if;
  import ledsd_pkg::*;

  lb_slave_t  xt_lb;
  logic [7:0] rdata;

  modport master (output xt_lb, input rdata);
  modport slave  (input xt_lb, output rdata);
endinterface

// File: rtl/ledsd_hex_decoder.sv
// Hex digit to active-high seven-segment pattern {g,f,e,d,c,b,a}.
module ledsd_hex_decoder (
  input  logic [3:0] code,
  output logic [6:0] seg7
);

  always_comb begin
    seg7 = 7'h00;
    case (code)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      4'hF: seg7 = 7'h71;
      default: seg7 = 7'h00;
    endcase
  end

endmodule

// File: rtl/ledsd_scan_lbus.sv
// Local-bus slave driving a scanned seven-segment display: per-digit data
// registers, a control register and a BLANK/SHOW scan state machine.
module ledsd_scan_lbus
  import ledsd_pkg::*;
#(
  parameter int         NUM          = 4,
  parameter int         COM          = 0,
  parameter logic [7:0] ADDR_BASE    = 8'd23,
  parameter int         SHOW_CYCLES  = 1000,
  parameter int         BLANK_CYCLES = 50
) (
  input  logic             lb_clk,
  input  logic             rst_n,
  ledsd_scan_lbus_if.slave lb,
  output logic [7:0]       seg,
  output logic [NUM-1:0]   dig
);

  localparam int CNT_MAX = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [2:0]       IDX_LAST   = 3'(NUM - 1);
  localparam logic [7:0]       CTRL_ADDR  = ADDR_BASE + 8'(NUM);
  localparam logic [7:0]       SEG_OFF    = (COM == 0) ? 8'h00 : 8'hFF;
  localparam logic [NUM-1:0]   DIG_OFF    = (COM == 0) ? {NUM{1'b1}} : {NUM{1'b0}};

  if (NUM < 1 || NUM > 8) begin : g_num_check
    $error("ledsd_scan_lbus: NUM must be in 1..8");
  end
  if (SHOW_CYCLES < 1) begin : g_show_check
    $error("ledsd_scan_lbus: SHOW_CYCLES must be at least 1");
  end
  if (BLANK_CYCLES < 1) begin : g_blank_check
    $error("ledsd_scan_lbus: BLANK_CYCLES must be at least 1");
  end

  scan_state_t      state_reg, state_next;
  logic [2:0]       idx_reg, idx_next, idx_inc;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       shadow_reg, shadow_next;
  logic             shadow_hex_reg, shadow_hex_next;
  logic             en_reg, en_next;
  logic             hex_reg, hex_next;
  logic             ctrl_wr;
  logic [7:0]       data_reg [NUM];
  logic [NUM-1:0]   data_wr;
  logic [7:0][7:0]  data_pad;
  logic [7:0]       rdata_mux;
  logic [6:0]       hex_seg7;
  logic [7:0]       seg_on;
  logic [NUM-1:0]   dig_sel;
  logic [7:0]       seg_reg, seg_next;
  logic [NUM-1:0]   dig_reg, dig_next;

  genvar gi;

  // ---------------- register file ----------------
  assign ctrl_wr  = MatchWLB(lb.xt_lb, CTRL_ADDR);
  assign en_next  = ctrl_wr ? lb.xt_lb.wdata[EN_BIT]  : en_reg;
  assign hex_next = ctrl_wr ? lb.xt_lb.wdata[HEX_BIT] : hex_reg;

  generate
    for (gi = 0; gi < NUM; gi++) begin : g_data_wr
      assign data_wr[gi] = MatchWLB(lb.xt_lb, ADDR_BASE + 8'(gi));
    end
    // Pad to 8 entries so the 3-bit digit index can select without range gaps.
    for (gi = 0; gi < 8; gi++) begin : g_data_pad
      if (gi < NUM) begin : g_real
        assign data_pad[gi] = data_reg[gi];
      end else begin : g_zero
        assign data_pad[gi] = 8'h00;
      end
    end
  endgenerate

  always_ff @(posedge lb_clk or negedge rst_n) begin
    if (!rst_n) begin
      en_reg  <= 1'b0;
      hex_reg <= 1'b0;
      for (int i = 0; i < NUM; i++) data_reg[i] <= 8'h00;
    end else begin
      en_reg  <= en_next;
      hex_reg <= hex_next;
      for (int i = 0; i < NUM; i++) begin
        if (data_wr[i]) data_reg[i] <= lb.xt_lb.wdata;
      end
    end
  end

  always_comb begin
    rdata_mux = 8'h00;
    for (int i = 0; i < NUM; i++) begin
      if (MatchRLB(lb.xt_lb, ADDR_BASE + 8'(i))) rdata_mux = data_reg[i];
    end
    if (MatchRLB(lb.xt_lb, CTRL_ADDR)) rdata_mux = {1'b0, idx_reg, 2'b00, hex_reg, en_reg};
  end

  assign lb.rdata = rdata_mux;

  // ---------------- scan state machine ----------------
  assign idx_inc = (idx_reg >= IDX_LAST) ? 3'd0 : idx_reg + 3'd1;

  always_ff @(posedge lb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      idx_reg        <= 3'd0;
      cnt_reg        <= '0;
      shadow_reg     <= 8'h00;
      shadow_hex_reg <= 1'b0;
      seg_reg        <= SEG_OFF;
      dig_reg        <= DIG_OFF;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      cnt_reg        <= cnt_next;
      shadow_reg     <= shadow_next;
      shadow_hex_reg <= shadow_hex_next;
      seg_reg        <= seg_next;
      dig_reg        <= dig_next;
    end
  end

  // Shadow captures the pre-write byte but the post-write mode, so a digit's
  // look is frozen for its whole slot.
  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    cnt_next        = cnt_reg;
    shadow_next     = shadow_reg;
    shadow_hex_next = shadow_hex_reg;
    if (!en_next || (idx_reg > IDX_LAST)) begin
      state_next = IDLE;
      idx_next   = 3'd0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next      = BLANK;
          idx_next        = 3'd0;
          cnt_next        = '0;
          shadow_next     = data_pad[0];
          shadow_hex_next = hex_next;
        end
        BLANK: begin
          if (cnt_reg >= BLANK_LAST) begin
            state_next = SHOW;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        SHOW: begin
          if (cnt_reg >= SHOW_LAST) begin
            state_next      = BLANK;
            cnt_next        = '0;
            idx_next        = idx_inc;
            shadow_next     = data_pad[idx_inc];
            shadow_hex_next = hex_next;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          idx_next   = 3'd0;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // ---------------- output pattern ----------------
  ledsd_hex_decoder u_hex (
    .code (shadow_next[3:0]),
    .seg7 (hex_seg7)
  );

  generate
    for (gi = 0; gi < NUM; gi++) begin : g_dig_sel
      assign dig_sel[gi] = (idx_next == 3'(gi));
    end
  endgenerate

  always_comb begin
    seg_on = shadow_next;
    if (shadow_hex_next) begin
      seg_on = shadow_next[HEX_BLANK_BIT] ? 8'h00 : {shadow_next[HEX_DP_BIT], hex_seg7};
    end
    seg_next = SEG_OFF;
    dig_next = DIG_OFF;
    if (state_next == SHOW) begin
      seg_next = (COM == 0) ? seg_on : ~seg_on;
      dig_next = (COM == 0) ? ~dig_sel : dig_sel;
    end
  end

  assign seg = seg_reg;
  assign dig = dig_reg;

endmodule

// File: tb/tb_ledsd_scan_lbus.sv
// Randomized bench for ledsd_scan_lbus: common-cathode and common-anode
// instances share one bus stream and are checked against a frame-time model.
module tb_ledsd_scan_lbus;
  import ledsd_pkg::*;

  localparam int         NUM    = 4;
  localparam int         SHOW   = 4;
  localparam int         BLANK  = 2;
  localparam int         SLOT   = SHOW + BLANK;
  localparam int         PERIOD = NUM * SLOT;
  localparam logic [7:0] BASE   = 8'd23;
  localparam logic [7:0] CTRL   = 8'd27;

  logic       lb_clk = 1'b0;
  logic       rst_n  = 1'b0;
  logic [7:0] seg0, seg1;
  logic [3:0] dig0, dig1;

  ledsd_scan_lbus_if bus0 ();
  ledsd_scan_lbus_if bus1 ();

  ledsd_scan_lbus #(.NUM(NUM), .COM(0), .ADDR_BASE(BASE), .SHOW_CYCLES(SHOW), .BLANK_CYCLES(BLANK))
    dut_cc (.lb_clk(lb_clk), .rst_n(rst_n), .lb(bus0), .seg(seg0), .dig(dig0));

  ledsd_scan_lbus #(.NUM(NUM), .COM(1), .ADDR_BASE(BASE), .SHOW_CYCLES(SHOW), .BLANK_CYCLES(BLANK))
    dut_ca (.lb_clk(lb_clk), .rst_n(rst_n), .lb(bus1), .seg(seg1), .dig(dig1));

  always #5 lb_clk = ~lb_clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: time t since enable within the frame, plus the byte/mode frozen at slot start.
  logic [7:0] mem [NUM];
  bit         m_en, m_hex;
  int         t;
  logic [7:0] snap;
  bit         snap_hex;
  logic [6:0] hex7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) mem[i] = 8'h00;
    m_en = 0; m_hex = 0; t = 0; snap = 8'h00; snap_hex = 0;
  endtask

  function automatic logic [7:0] lit_pattern();
    if (!snap_hex) return snap;
    if (snap[5]) return 8'h00;
    return {snap[4], hex7[snap[3:0]]};
  endfunction

  function automatic logic [7:0] model_read(input lb_slave_t req);
    int a;
    if (!req.rd) return 8'h00;
    a = int'(req.addr) - int'(BASE);
    if (a >= 0 && a < NUM) return mem[a];
    if (req.addr == CTRL) return {1'b0, 3'(t / SLOT), 2'b00, m_hex, m_en};
    return 8'h00;
  endfunction

  task automatic model_edge(input lb_slave_t req);
    bit en_new;
    int a;
    en_new = m_en;
    if (req.wr && req.addr == CTRL) begin
      en_new = req.wdata[0];
      m_hex  = req.wdata[1];
    end
    if (!en_new) begin
      t = 0;
    end else if (!m_en) begin
      t = 0; snap = mem[0]; snap_hex = m_hex;
    end else begin
      t = (t + 1) % PERIOD;
      if (t % SLOT == 0) begin
        snap = mem[t / SLOT]; snap_hex = m_hex;
      end
    end
    m_en = en_new;
    a = int'(req.addr) - int'(BASE);
    if (req.wr && a >= 0 && a < NUM) mem[a] = req.wdata;
  endtask

  function automatic lb_slave_t mk_wr(input logic [7:0] addr, input logic [7:0] data);
    lb_slave_t r;
    r = '0; r.wr = 1'b1; r.addr = addr; r.wdata = data;
    return r;
  endfunction

  function automatic lb_slave_t rand_req();
    lb_slave_t r;
    int p;
    r = '0;
    p = $urandom_range(0, 99);
    if (p < 2) begin
      r.wr = 1'b1; r.addr = CTRL; r.wdata = 8'($urandom);
      r.wdata[0] = ($urandom_range(0, 9) < 8);
    end else if (p < 10) begin
      r.wr = 1'b1; r.addr = BASE + 8'($urandom_range(0, NUM - 1)); r.wdata = 8'($urandom);
    end else if (p < 40) begin
      r.rd = 1'b1; r.addr = 8'($urandom_range(20, 30));
    end
    return r;
  endfunction

  task automatic cycle(input lb_slave_t req);
    logic [7:0] exp_rd, pat, exp_seg, exp_seg_ca;
    logic [3:0] sel, exp_dig, exp_dig_ca;
    bit         lit;
    int         d;
    @(negedge lb_clk);
    bus0.xt_lb = req;
    bus1.xt_lb = req;
    if (req.wr) $display("%0t write addr=%0d data=0x%02h", $time, req.addr, req.wdata);
    #1;
    exp_rd = model_read(req);
    check_eq("rdata_cc", 32'(bus0.rdata), 32'(exp_rd));
    check_eq("rdata_ca", 32'(bus1.rdata), 32'(exp_rd));
    @(posedge lb_clk);
    model_edge(req);
    #1;
    lit        = m_en && ((t % SLOT) >= BLANK);
    d          = t / SLOT;
    sel        = 4'b0001 << d;
    pat        = lit_pattern();
    exp_seg    = lit ? pat : 8'h00;
    exp_seg_ca = ~exp_seg;
    exp_dig    = lit ? ~sel : 4'hF;
    exp_dig_ca = ~exp_dig;
    check_eq("seg_cc", 32'(seg0), 32'(exp_seg));
    check_eq("dig_cc", 32'(dig0), 32'(exp_dig));
    check_eq("seg_ca", 32'(seg1), 32'(exp_seg_ca));
    check_eq("dig_ca", 32'(dig1), 32'(exp_dig_ca));
  endtask

  lb_slave_t idle_req;
  lb_slave_t rd_req;

  initial begin
    model_reset();
    idle_req   = '0;
    bus0.xt_lb = '0;
    bus1.xt_lb = '0;
    repeat (2) @(posedge lb_clk);
    #1;
    check_eq("reset_seg_cc", 32'(seg0), 32'h00);
    check_eq("reset_dig_cc", 32'(dig0), 32'hF);
    check_eq("reset_seg_ca", 32'(seg1), 32'hFF);
    check_eq("reset_dig_ca", 32'(dig1), 32'h0);
    rd_req = '0; rd_req.rd = 1'b1; rd_req.addr = CTRL;
    bus0.xt_lb = rd_req;
    #1;
    check_eq("reset_ctrl_read", 32'(bus0.rdata), 32'h00);
    @(negedge lb_clk);
    rst_n = 1'b1;

    // Hex scan of 0, 1 with dp, 8 and a blanked F.
    cycle(mk_wr(8'd23, 8'h00));
    cycle(mk_wr(8'd24, 8'h11));
    cycle(mk_wr(8'd25, 8'h08));
    cycle(mk_wr(8'd26, 8'h2F));
    cycle(mk_wr(CTRL, 8'h03));
    repeat (2 * PERIOD) cycle(idle_req);
    cycle(mk_wr(8'd24, 8'h20));
    repeat (PERIOD) cycle(idle_req);

    for (int i = 0; i < 3000; i++) cycle(rand_req());

    // Asynchronous reset asserted in the middle of a lit digit.
    cycle(mk_wr(CTRL, 8'h01));
    repeat (3) cycle(idle_req);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst_seg_cc", 32'(seg0), 32'h00);
    check_eq("async_rst_dig_cc", 32'(dig0), 32'hF);
    check_eq("async_rst_seg_ca", 32'(seg1), 32'hFF);
    check_eq("async_rst_dig_ca", 32'(dig1), 32'h0);
    bus0.xt_lb = rd_req;
    bus1.xt_lb = rd_req;
    #1;
    check_eq("async_rst_ctrl_cc", 32'(bus0.rdata), 32'h00);
    check_eq("async_rst_ctrl_ca", 32'(bus1.rdata), 32'h00);
    @(negedge lb_clk);
    rst_n = 1'b1;
    cycle(mk_wr(8'd23, 8'hA5));
    cycle(mk_wr(CTRL, 8'h01));
    repeat (PERIOD + 4) cycle(idle_req);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
